// File: rtl/instr_feed_fifo.sv
// Instruction feeder FIFO: buffers host words and presents the oldest
// one to the processor, advancing on each control-circuit Done pulse.
module instr_feed_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  input  logic                  cpu_done,
  output logic [CW-1:0]         count,
  output logic [7:0]            issue_count,
  output logic                  underflow_err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign empty = (count == '0);

  // Ready comes from registered state only; no pass-through when full.
  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready;
  assign pop      = cpu_done & ~empty;

  assign instr_valid = ~empty;
  assign instr_out   = empty ? NOP_WORD : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      issue_count   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        issue_count <= issue_count + 8'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Done with nothing buffered means the processor ran ahead.
      if (cpu_done && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule
